// File: rtl/fft_pkg.sv
// Shared definitions for the 32-point SDF FFT pipeline.
// Widths, delay depths and the common stage state type.
package fft_pkg;

  localparam int FFT_N    = 32;

  localparam int S4_IN_W  = 16;
  localparam int S4_OUT_W = 17;
  localparam int S4_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } sdf_state_t;

endpackage

// File: rtl/fft_stage4_if.sv
// Stream bundle between stage 3, stage 4 and stage 5.
// The stage itself sits on the slave side.
interface fft_stage4_if
  import fft_pkg::*;
#(
  parameter int IN_W  = S4_IN_W,
  parameter int OUT_W = S4_OUT_W
);

  logic             valid_i;
  logic [IN_W-1:0]  data_in_r;
  logic [IN_W-1:0]  data_in_i;
  logic             valid_o;
  logic [OUT_W-1:0] data_out_r;
  logic [OUT_W-1:0] data_out_i;
  logic             err_o;

  modport master (
    output valid_i, data_in_r, data_in_i,
    input  valid_o, data_out_r, data_out_i, err_o
  );

  modport slave (
    input  valid_i, data_in_r, data_in_i,
    output valid_o, data_out_r, data_out_i, err_o
  );

endinterface

// File: rtl/fft_sdf_delay.sv
// Complex delay store for SDF stages.
// Combinational read of the addressed slot, write at the clock edge.
module fft_sdf_delay #(
  parameter int DEPTH = 2,
  parameter int W     = 17,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_re,
  input  logic [W-1:0]  wr_im,
  output logic [W-1:0]  rd_re,
  output logic [W-1:0]  rd_im
);

  logic [W-1:0] mem_re [DEPTH];
  logic [W-1:0] mem_im [DEPTH];

  // Old contents stay visible until the edge that overwrites them.
  assign rd_re = mem_re[addr];
  assign rd_im = mem_im[addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_re[i] <= '0;
        mem_im[i] <= '0;
      end
    end else if (wr_en) begin
      mem_re[addr] <= wr_re;
      mem_im[addr] <= wr_im;
    end
  end

endmodule

// File: rtl/fft_stage4.sv
// Radix-2 DIF SDF stage 4: 2-apart butterfly, twiddles {1, -j}.
// 16-bit complex in, 17-bit complex out, latency 2 cycles.
module fft_stage4
  import fft_pkg::*;
#(
  parameter int FRAME_LEN = FFT_N,
  parameter int IN_W      = S4_IN_W,
  parameter int OUT_W     = S4_OUT_W
) (
  input  logic         clk,
  input  logic         rst,
  fft_stage4_if.slave  bus
);

  localparam int CW = $clog2(FRAME_LEN);

  sdf_state_t state, state_nx;

  logic [CW-1:0] cnt, cnt_nx;
  logic          pending, pending_nx;
  logic          vo_nx, err_nx;
  logic          wr_en;

  logic [OUT_W-1:0] x_re, x_im;
  logic [OUT_W-1:0] d_re, d_im;
  logic [OUT_W-1:0] sum_re, sum_im;
  logic [OUT_W-1:0] dif_re, dif_im;
  logic [OUT_W-1:0] tw_re, tw_im;
  logic [OUT_W-1:0] wr_re, wr_im;
  logic [OUT_W-1:0] o_re_nx, o_im_nx;

  logic accept, gap, boundary, abort, in_drain;

  assign x_re = {{(OUT_W-IN_W){bus.data_in_r[IN_W-1]}},
                 bus.data_in_r};
  assign x_im = {{(OUT_W-IN_W){bus.data_in_i[IN_W-1]}},
                 bus.data_in_i};

  assign sum_re = d_re + x_re;
  assign sum_im = d_im + x_im;
  assign dif_re = d_re - x_re;
  assign dif_im = d_im - x_im;

  // Odd slot takes -j: swap, then negate the new imaginary part.
  assign tw_re = cnt[0] ? dif_im : dif_re;
  assign tw_im = cnt[0] ? -dif_re : dif_im;

  assign accept   = bus.valid_i && (state != DRAIN);
  assign gap      = (state == RUN) && !bus.valid_i;
  assign boundary = gap && (cnt == '0);
  assign abort    = gap && (cnt != '0);
  assign in_drain = (state == DRAIN);

  fft_sdf_delay #(
    .DEPTH (S4_DEPTH),
    .W     (OUT_W)
  ) u_dly (
    .clk   (clk),
    .rst   (rst),
    .addr  (cnt[0]),
    .wr_en (wr_en),
    .wr_re (wr_re),
    .wr_im (wr_im),
    .rd_re (d_re),
    .rd_im (d_im)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      pending <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      pending <= pending_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.valid_i) state_nx = RUN;
      RUN: begin
        if (!bus.valid_i)
          state_nx = (cnt == '0) ? DRAIN : IDLE;
      end
      DRAIN:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    cnt_nx     = cnt;
    pending_nx = pending;
    vo_nx      = 1'b0;
    err_nx     = 1'b0;
    o_re_nx    = bus.data_out_r;
    o_im_nx    = bus.data_out_i;
    wr_en      = 1'b0;
    wr_re      = x_re;
    wr_im      = x_im;
    unique case (1'b1)
      accept && !cnt[1]: begin
        cnt_nx  = cnt + CW'(1);
        wr_en   = 1'b1;
        vo_nx   = pending;
        o_re_nx = d_re;
        o_im_nx = d_im;
      end
      accept && cnt[1]: begin
        cnt_nx     = cnt + CW'(1);
        wr_en      = 1'b1;
        wr_re      = tw_re;
        wr_im      = tw_im;
        vo_nx      = 1'b1;
        o_re_nx    = sum_re;
        o_im_nx    = sum_im;
        pending_nx = 1'b1;
      end
      // Frame ended with no follower: first drained difference.
      boundary: begin
        cnt_nx  = CW'(1);
        vo_nx   = pending;
        o_re_nx = d_re;
        o_im_nx = d_im;
      end
      abort: begin
        cnt_nx     = '0;
        pending_nx = 1'b0;
        err_nx     = 1'b1;
      end
      in_drain: begin
        cnt_nx     = '0;
        pending_nx = 1'b0;
        vo_nx      = pending;
        o_re_nx    = d_re;
        o_im_nx    = d_im;
        err_nx     = bus.valid_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.valid_o    <= 1'b0;
      bus.data_out_r <= '0;
      bus.data_out_i <= '0;
      bus.err_o      <= 1'b0;
    end else begin
      bus.valid_o    <= vo_nx;
      bus.data_out_r <= o_re_nx;
      bus.data_out_i <= o_im_nx;
      bus.err_o      <= err_nx;
    end
  end

endmodule

// File: tb/tb_fft_stage4.sv
// Self-checking bench for fft_stage4: per-edge reference model
// built from the butterfly output-order rules, plus literal pins.
module tb_fft_stage4;
  import fft_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fft_stage4_if bus ();

  fft_stage4 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int re;
    int im;
  } cpx_t;

  cpx_t exp_o [int];
  bit   exp_err [int];
  int   got_v [int];
  int   got_re [int];
  int   got_im [int];
  int   got_err [int];

  int ec = 0;
  int nchk = 0;
  int nerr = 0;
  bit chk_en = 1'b0;

  int xr [32];
  int xi [32];

  function automatic void chk(string nm, int act, int req);
    nchk++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endfunction

  // Output j of a frame whose sample 0 lands on edge e0 is due at e0+j+2.
  function automatic void model_frame(int e0, int n);
    for (int j = 0; j < 32; j++) begin
      int a;
      cpx_t v;
      a = (j / 4) * 4;
      if (n == 32 || j <= n - 3) begin
        case (j % 4)
          0: begin
            v.re = xr[a] + xr[a+2];
            v.im = xi[a] + xi[a+2];
          end
          1: begin
            v.re = xr[a+1] + xr[a+3];
            v.im = xi[a+1] + xi[a+3];
          end
          2: begin
            v.re = xr[a] - xr[a+2];
            v.im = xi[a] - xi[a+2];
          end
          default: begin
            v.re = xi[a+1] - xi[a+3];
            v.im = -(xr[a+1] - xr[a+3]);
          end
        endcase
        exp_o[e0 + j + 2] = v;
      end
    end
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      ec++;
      #1;
      got_v[ec]   = int'(bus.valid_o);
      got_re[ec]  = int'($signed(bus.data_out_r));
      got_im[ec]  = int'($signed(bus.data_out_i));
      got_err[ec] = int'(bus.err_o);
      if (chk_en) begin
        chk($sformatf("valid_o@%0d", ec), got_v[ec],
            int'(exp_o.exists(ec)));
        if (bus.valid_o && exp_o.exists(ec)) begin
          chk($sformatf("re@%0d", ec), got_re[ec], exp_o[ec].re);
          chk($sformatf("im@%0d", ec), got_im[ec], exp_o[ec].im);
        end
        chk($sformatf("err_o@%0d", ec), got_err[ec],
            int'(exp_err.exists(ec)));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic frame(input int n, output int e0);
    @(negedge clk);
    e0 = ec + 1;
    model_frame(e0, n);
    if (n < 32) exp_err[e0 + n] = 1'b1;
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk);
      bus.valid_i   = 1'b1;
      bus.data_in_r = 16'(xr[k]);
      bus.data_in_i = 16'(xi[k]);
    end
    if (n < 32) begin
      @(negedge clk);
      bus.valid_i = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.valid_i = 1'b0;
    end
  endtask

  task automatic drain_pulse();
    @(negedge clk);
    bus.valid_i = 1'b0;
    @(negedge clk);
    bus.valid_i   = 1'b1;
    bus.data_in_r = 16'($urandom);
    bus.data_in_i = 16'($urandom);
    exp_err[ec + 1] = 1'b1;
    @(negedge clk);
    bus.valid_i = 1'b0;
  endtask

  task automatic clear_x();
    for (int k = 0; k < 32; k++) begin
      xr[k] = 0;
      xi[k] = 0;
    end
  endtask

  task automatic rand_x();
    logic [15:0] t;
    for (int k = 0; k < 32; k++) begin
      t = 16'($urandom);
      xr[k] = int'($signed(t));
      t = 16'($urandom);
      xi[k] = int'($signed(t));
    end
  endtask

  initial begin
    int e1, e2, sel;
    rst           = 1'b1;
    bus.valid_i   = 1'b0;
    bus.data_in_r = '0;
    bus.data_in_i = '0;
    repeat (3) @(negedge clk);
    chk("reset valid_o", int'(bus.valid_o), 0);
    chk("reset data_r", int'(bus.data_out_r), 0);
    chk("reset data_i", int'(bus.data_out_i), 0);
    chk("reset err_o", int'(bus.err_o), 0);
    rst    = 1'b0;
    chk_en = 1'b1;

    // Impulse, then drain with a stray sample on the last drain cycle.
    clear_x();
    xr[0] = 1;
    frame(32, e1);
    drain_pulse();
    idle(3);
    chk("imp v E+1", got_v[e1+1], 0);
    chk("imp v E+2", got_v[e1+2], 1);
    chk("imp out0", got_re[e1+2], 1);
    chk("imp out1", got_re[e1+3], 0);
    chk("imp out2", got_re[e1+4], 1);
    chk("imp v E+33", got_v[e1+33], 1);
    chk("imp v E+34", got_v[e1+34], 0);
    chk("drain err", got_err[e1+33], 1);

    clear_x();
    xr[1] = 100;
    xi[1] = 50;
    frame(32, e1);
    idle(3);
    chk("tw out1 re", got_re[e1+3], 100);
    chk("tw out1 im", got_im[e1+3], 50);
    chk("tw out3 re", got_re[e1+5], 50);
    chk("tw out3 im", got_im[e1+5], -100);

    clear_x();
    xr[1] = -32768;
    xr[3] = 32767;
    frame(32, e1);
    idle(3);
    chk("ext out1 re", got_re[e1+3], -1);
    chk("ext out3 re", got_re[e1+5], 0);
    chk("ext out3 im", got_im[e1+5], 65535);

    for (int k = 0; k < 32; k++) begin
      xr[k] = k;
      xi[k] = -k;
    end
    frame(32, e1);
    for (int k = 0; k < 32; k++) begin
      xr[k] = 32 + k;
      xi[k] = -(32 + k);
    end
    frame(32, e2);
    idle(3);
    chk("b2b start", e2, e1 + 32);
    chk("b2b seam v", got_v[e2+1], 1);
    chk("b2b f2 out0", got_re[e2+2], 66);
    chk("b2b f2 out0 im", got_im[e2+2], -66);
    chk("b2b f2 out2", got_re[e2+4], -2);

    rand_x();
    frame(10, e1);
    rand_x();
    frame(32, e2);
    idle(3);
    chk("abort err", got_err[e1+10], 1);
    chk("abort err once", got_err[e1+11], 0);
    chk("abort last out", got_v[e1+9], 1);
    chk("abort no out", got_v[e1+10], 0);

    // Asynchronous reset partway into a frame.
    chk_en = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      bus.valid_i   = 1'b1;
      bus.data_in_r = 16'(k + 7);
      bus.data_in_i = 16'(3 * k + 1);
    end
    @(posedge clk);
    #3;
    rst         = 1'b1;
    bus.valid_i = 1'b0;
    #1;
    chk("mid rst valid_o", int'(bus.valid_o), 0);
    chk("mid rst data_r", int'(bus.data_out_r), 0);
    chk("mid rst data_i", int'(bus.data_out_i), 0);
    chk("mid rst err_o", int'(bus.err_o), 0);
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;
    rand_x();
    frame(32, e1);
    idle(3);

    repeat (25) begin
      rand_x();
      sel = int'($urandom_range(0, 9));
      if (sel < 2) begin
        frame(int'($urandom_range(3, 31)), e1);
      end else begin
        frame(32, e1);
        if (sel >= 8)
          drain_pulse();
        else if (sel >= 5)
          idle(int'($urandom_range(2, 4)));
      end
    end
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
